// File: rtl/game_timer_pkg.sv
// Shared types and constants for the game countdown timer.
// Holds the FSM state enum, BCD digit types and conversion helpers.
package game_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t mt;
    bcd_t mo;
    bcd_t st;
    bcd_t so;
  } mmss_t;

  localparam mmss_t MMSS_MAX = '{
    mt: 4'd9, mo: 4'd9, st: 4'd5, so: 4'd9
  };

  localparam mmss_t MMSS_ZERO = '0;

  function automatic logic [6:0] bcd2_to_bin(
    input bcd_t t,
    input bcd_t o
  );
    return 7'(t) * 7'd10 + 7'(o);
  endfunction

  function automatic logic [7:0] bin_to_bcd2(
    input logic [6:0] v
  );
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/game_countdown_timer_bcd_mmss_adder.sv
// Adds or subtracts 0..59 seconds to an MM:SS BCD value.
// Adds saturate at 99:59; subtracts floor at 00:00.
module bcd_mmss_adder
  import game_timer_pkg::*;
(
  input  mmss_t      t_i,
  input  logic       sub_i,
  input  logic [5:0] delta_i,
  output mmss_t      t_o
);

  logic [6:0] s_bin;
  logic [6:0] m_bin;
  logic [6:0] dlt;
  logic [6:0] s_sum;
  logic [6:0] m_sum;
  logic       sat;
  logic       flr;

  // Work in binary seconds/minutes, then re-encode as BCD.
  always_comb begin
    s_bin = bcd2_to_bin(t_i.st, t_i.so);
    m_bin = bcd2_to_bin(t_i.mt, t_i.mo);
    dlt   = {1'b0, delta_i};
    s_sum = s_bin;
    m_sum = m_bin;
    sat   = 1'b0;
    flr   = 1'b0;
    if (sub_i) begin
      if (s_bin >= dlt) begin
        s_sum = s_bin - dlt;
      end else if (m_bin == 7'd0) begin
        flr = 1'b1;
      end else begin
        s_sum = s_bin + 7'd60 - dlt;
        m_sum = m_bin - 7'd1;
      end
    end else begin
      s_sum = s_bin + dlt;
      if (s_sum >= 7'd60) begin
        s_sum = s_sum - 7'd60;
        m_sum = m_bin + 7'd1;
      end
      if (m_sum > 7'd99) begin
        sat = 1'b1;
      end
    end
    if (sat) begin
      t_o = MMSS_MAX;
    end else if (flr) begin
      t_o = MMSS_ZERO;
    end else begin
      t_o = {bin_to_bcd2(m_sum), bin_to_bcd2(s_sum)};
    end
  end

endmodule

// File: rtl/game_countdown_timer.sv
// MM:SS game countdown timer with pause, bonus time and expiry pulse.
// Time is stored as BCD digits; all outputs come straight from flops.
module game_countdown_timer
  import game_timer_pkg::*;
#(
  parameter int INIT_MIN  = 1,
  parameter int INIT_SEC  = 30,
  parameter int WARN_SEC  = 10,
  parameter int BONUS_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_sec,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic       bonus,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       warning,
  output logic       time_up,
  output logic       expired
);

  localparam mmss_t INIT_T = {
    bin_to_bcd2(7'(INIT_MIN)),
    bin_to_bcd2(7'(INIT_SEC))
  };

  state_e state_q, state_d, st_sel;
  mmss_t  time_q, time_d;
  mmss_t  dec_t, bon_t;
  logic   tick_en, bon_en;
  logic   running_q, running_d;
  logic   warning_q, warning_d;
  logic   time_up_q, time_up_d;
  logic   expired_q, expired_d;

  bcd_mmss_adder u_dec (
    .t_i     (time_q),
    .sub_i   (1'b1),
    .delta_i ({5'd0, tick_en}),
    .t_o     (dec_t)
  );

  bcd_mmss_adder u_bonus (
    .t_i     (dec_t),
    .sub_i   (1'b0),
    .delta_i (bon_en ? 6'(BONUS_SEC) : 6'd0),
    .t_o     (bon_t)
  );

  // State selection first: load > pause > start.
  always_comb begin
    st_sel = state_q;
    if (load) begin
      st_sel = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!pause && start) begin
            st_sel = (time_q == MMSS_ZERO) ?
                     ST_EXPIRED : ST_RUNNING;
          end
        end
        ST_RUNNING: begin
          if (pause) st_sel = ST_PAUSED;
        end
        ST_PAUSED: begin
          if (!pause && start) st_sel = ST_RUNNING;
        end
        default: st_sel = ST_EXPIRED;
      endcase
    end
    tick_en = one_sec && (state_q == ST_RUNNING) &&
              (st_sel == ST_RUNNING);
    bon_en  = bonus && !load && (st_sel != ST_EXPIRED);
  end

  // Time update, expiry detection and registered flag values.
  always_comb begin
    state_d = st_sel;
    time_d  = bon_t;
    if (load) begin
      time_d = INIT_T;
    end else if (st_sel == ST_EXPIRED) begin
      time_d = MMSS_ZERO;
    end else if (tick_en && bon_t == MMSS_ZERO) begin
      state_d = ST_EXPIRED;
      time_d  = MMSS_ZERO;
    end
    running_d = (state_d == ST_RUNNING);
    expired_d = (state_d == ST_EXPIRED);
    time_up_d = expired_d && (state_q != ST_EXPIRED);
    warning_d = ((state_d == ST_RUNNING) ||
                 (state_d == ST_PAUSED)) &&
                (time_d != MMSS_ZERO) &&
                (time_d.mt == 4'd0) && (time_d.mo == 4'd0) &&
                (bcd2_to_bin(time_d.st, time_d.so) <=
                 7'(WARN_SEC));
  end

  // State, time and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      time_q    <= INIT_T;
      running_q <= 1'b0;
      warning_q <= 1'b0;
      time_up_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      running_q <= running_d;
      warning_q <= warning_d;
      time_up_q <= time_up_d;
      expired_q <= expired_d;
    end
  end

  assign min_tens = time_q.mt;
  assign min_ones = time_q.mo;
  assign sec_tens = time_q.st;
  assign sec_ones = time_q.so;
  assign running  = running_q;
  assign warning  = warning_q;
  assign time_up  = time_up_q;
  assign expired  = expired_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench for game_countdown_timer at default parameters.
// Expected digits are derived from remaining seconds in the bench.
module tb_game_countdown_timer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic one_sec = 1'b0;
  logic load = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic bonus = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic running, warning, time_up, expired;
  logic [15:0] dig;
  int total = 0;
  int bad = 0;

  assign dig = {min_tens, min_ones, sec_tens, sec_ones};

  always #5 clk = ~clk;

  game_countdown_timer dut (
    .clk      (clk),
    .reset    (reset),
    .one_sec  (one_sec),
    .load     (load),
    .start    (start),
    .pause    (pause),
    .bonus    (bonus),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .running  (running),
    .warning  (warning),
    .time_up  (time_up),
    .expired  (expired)
  );

  function automatic logic [15:0] exp_t(input int rem);
    int m, s;
    m = rem / 60;
    s = rem % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    one_sec = 1'b1;
    cyc();
    one_sec = 1'b0;
  endtask

  task automatic p_load();
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic p_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic p_pause();
    pause = 1'b1;
    cyc();
    pause = 1'b0;
  endtask

  task automatic p_bonus();
    bonus = 1'b1;
    cyc();
    bonus = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    total++;
    if (dig !== 16'h0130) begin
      bad++;
      $display("FAIL reset_digits got %h want 0130", dig);
    end
    total++;
    if ({running, warning, time_up, expired} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got %b want 0000",
               {running, warning, time_up, expired});
    end
  endtask

  task automatic test_countdown();
    int rem;
    p_load();
    p_start();
    total++;
    if (running !== 1'b1 || dig !== 16'h0130) begin
      bad++;
      $display("FAIL start_run got r=%b %h want r=1 0130",
               running, dig);
    end
    for (int i = 1; i <= 90; i++) begin
      tick();
      rem = 90 - i;
      total++;
      if (dig !== exp_t(rem)) begin
        bad++;
        $display("FAIL cd_digits i=%0d got %h want %h",
                 i, dig, exp_t(rem));
      end
      total++;
      if (time_up !== (i == 90) || expired !== (i == 90)) begin
        bad++;
        $display("FAIL cd_flags i=%0d got tu=%b ex=%b want %b",
                 i, time_up, expired, (i == 90));
      end
      total++;
      if (warning !== (rem > 0 && rem <= 10)) begin
        bad++;
        $display("FAIL cd_warn i=%0d got %b want %b",
                 i, warning, (rem > 0 && rem <= 10));
      end
    end
    cyc();
    total++;
    if (time_up !== 1'b0 || expired !== 1'b1 ||
        running !== 1'b0 || dig !== 16'h0000) begin
      bad++;
      $display("FAIL post_expiry got tu=%b ex=%b r=%b %h want 0 1 0 0000",
               time_up, expired, running, dig);
    end
  endtask

  task automatic test_expired_hold();
    start = 1'b1;
    bonus = 1'b1;
    one_sec = 1'b1;
    cyc();
    start = 1'b0;
    bonus = 1'b0;
    one_sec = 1'b0;
    total++;
    if (dig !== 16'h0000 || expired !== 1'b1 ||
        time_up !== 1'b0 || running !== 1'b0) begin
      bad++;
      $display("FAIL exp_hold got %h ex=%b tu=%b r=%b want 0000 1 0 0",
               dig, expired, time_up, running);
    end
    p_load();
    total++;
    if (dig !== 16'h0130 || expired !== 1'b0 ||
        running !== 1'b0 || warning !== 1'b0) begin
      bad++;
      $display("FAIL exp_load got %h ex=%b r=%b w=%b want 0130 0 0 0",
               dig, expired, running, warning);
    end
  endtask

  task automatic test_pause();
    p_load();
    p_start();
    repeat (45) tick();
    total++;
    if (dig !== 16'h0045) begin
      bad++;
      $display("FAIL pause_pre got %h want 0045", dig);
    end
    p_pause();
    total++;
    if (running !== 1'b0 || dig !== 16'h0045) begin
      bad++;
      $display("FAIL paused got r=%b %h want r=0 0045", running, dig);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (dig !== 16'h0045) begin
        bad++;
        $display("FAIL pause_hold i=%0d got %h want 0045", i, dig);
      end
    end
    p_start();
    total++;
    if (running !== 1'b1 || dig !== 16'h0045) begin
      bad++;
      $display("FAIL resume got r=%b %h want r=1 0045", running, dig);
    end
    tick();
    total++;
    if (dig !== 16'h0044) begin
      bad++;
      $display("FAIL resume_tick got %h want 0044", dig);
    end
  endtask

  task automatic test_bonus();
    p_load();
    p_start();
    repeat (35) tick();
    total++;
    if (dig !== 16'h0055) begin
      bad++;
      $display("FAIL bonus_pre got %h want 0055", dig);
    end
    p_bonus();
    total++;
    if (dig !== 16'h0105 || running !== 1'b1) begin
      bad++;
      $display("FAIL bonus_carry got %h r=%b want 0105 r=1",
               dig, running);
    end
    p_load();
    p_start();
    repeat (5) tick();
    p_pause();
    repeat (591) p_bonus();
    total++;
    if (dig !== 16'h9955) begin
      bad++;
      $display("FAIL bonus_9955 got %h want 9955", dig);
    end
    p_bonus();
    total++;
    if (dig !== 16'h9959) begin
      bad++;
      $display("FAIL bonus_sat got %h want 9959", dig);
    end
    p_bonus();
    total++;
    if (dig !== 16'h9959 || running !== 1'b0) begin
      bad++;
      $display("FAIL bonus_sat2 got %h r=%b want 9959 r=0",
               dig, running);
    end
  endtask

  task automatic test_tick_bonus();
    p_load();
    p_start();
    repeat (89) tick();
    total++;
    if (dig !== 16'h0001 || warning !== 1'b1) begin
      bad++;
      $display("FAIL tb_pre got %h w=%b want 0001 w=1", dig, warning);
    end
    one_sec = 1'b1;
    bonus = 1'b1;
    cyc();
    one_sec = 1'b0;
    bonus = 1'b0;
    total++;
    if (dig !== 16'h0010) begin
      bad++;
      $display("FAIL tb_net got %h want 0010", dig);
    end
    total++;
    if ({running, time_up, expired, warning} !== 4'b1001) begin
      bad++;
      $display("FAIL tb_flags got %b want 1001",
               {running, time_up, expired, warning});
    end
    tick();
    total++;
    if (dig !== 16'h0009) begin
      bad++;
      $display("FAIL tb_next got %h want 0009", dig);
    end
  endtask

  task automatic test_reset_mid();
    p_load();
    p_start();
    repeat (53) tick();
    total++;
    if (dig !== 16'h0037) begin
      bad++;
      $display("FAIL rm_pre got %h want 0037", dig);
    end
    reset = 1'b1;
    start = 1'b1;
    one_sec = 1'b1;
    bonus = 1'b1;
    cyc();
    reset = 1'b0;
    start = 1'b0;
    one_sec = 1'b0;
    bonus = 1'b0;
    total++;
    if (dig !== 16'h0130) begin
      bad++;
      $display("FAIL rm_digits got %h want 0130", dig);
    end
    total++;
    if ({running, warning, time_up, expired} !== 4'b0000) begin
      bad++;
      $display("FAIL rm_flags got %b want 0000",
               {running, warning, time_up, expired});
    end
    tick();
    total++;
    if (dig !== 16'h0130 || running !== 1'b0) begin
      bad++;
      $display("FAIL rm_idle got %h r=%b want 0130 r=0", dig, running);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_countdown();
    test_expired_hold();
    test_pause();
    test_bonus();
    test_tick_bonus();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
